nibble_serial_addsub_ctrl: RTL and testbench

Sequencer that performs a 16-bit add or subtract by time-multiplexing one 4-bit ripple-carry adder over four clock cycles, least-significant nibble first. The carry is held in a register between nibbles. It is the area-reduced counterpart of the parallel 16-bit adder/subtractor. A start/busy/done handshake connects it to the issuing logic.

---
 rtl/nibble_serial_addsub_ctrl_pkg.sv | 20 ++
 rtl/nibble_serial_addsub_ctrl_rca4.sv | 24 ++
 rtl/nibble_serial_addsub_ctrl.sv | 90 +++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer.
// State encodings are kept as plain 2-bit constants for compatibility with existing code.
package nibble_serial_addsub_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned DATA_W   = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef logic [DATA_W-1:0]   word_t;

  // Two's-complement overflow from the final operand and sum sign bits.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_ctrl_rca4.sv
// 4-bit ripple-carry adder slice reused by the nibble-serial sequencer.
module nibble_serial_addsub_ctrl_rca4
  import nibble_serial_addsub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// 16-bit add/subtract computed one nibble per cycle on a shared 4-bit adder,
// least-significant nibble first, with a start/busy/done handshake.
module nibble_serial_addsub_ctrl
  import nibble_serial_addsub_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sub,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              ovf
);

  localparam logic [1:0] IDX_LAST = 2'(NIBBLES - 1);

  logic [1:0]        state;
  logic [1:0]        idx;
  logic              carry;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_eff_r;

  nibble_t           a_nib;
  nibble_t           b_nib;
  nibble_t           sum_nib;
  logic              add_cout;

  assign a_nib = a_r[{idx, 2'b00} +: NIBBLE_W];
  assign b_nib = b_eff_r[{idx, 2'b00} +: NIBBLE_W];

  nibble_serial_addsub_ctrl_rca4 u_rca4 (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (sum_nib),
    .cout (add_cout)
  );

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_r     <= '0;
      b_eff_r <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            a_r     <= a;
            b_eff_r <= sub ? ~b : b;
            carry   <= sub;
            idx     <= '0;
            result  <= '0;
            state   <= ST_RUN;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_RUN: begin
          result[{idx, 2'b00} +: NIBBLE_W] <= sum_nib;
          carry <= add_cout;
          if (idx == IDX_LAST) begin
            // Bit 15 is taken straight from the adder; the result register updates on this same edge.
            cout  <= add_cout;
            ovf   <= signed_ovf(a_r[DATA_W-1], b_eff_r[DATA_W-1], sum_nib[NIBBLE_W-1]);
            state <= ST_DONE;
          end else begin
            idx   <= idx + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Self-checking bench: directed and random add/sub operations against an integer-arithmetic model.
module tb_nibble_serial_addsub_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, result} from plain signed/unsigned integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    int          sx, sy, sr;
    int unsigned ux, uy, ur;
    logic        c, v;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    sr = s ? sx - sy : sx + sy;
    ur = s ? ux - uy : ux + uy;
    c  = s ? (ux >= uy) : (ux + uy > 32'hFFFF);
    v  = (sr > 32767) || (sr < -32768);
    return {v, c, ur[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic s);
    a     = x;
    b     = y;
    sub   = s;
    start = 1'b1;
  endtask

  // Waits for done after an issue(); junk=1 keeps start high with fresh operands while busy.
  task automatic wait_done(input logic [15:0] x, input logic [15:0] y, input logic s,
                           input bit junk, input string tag);
    logic [17:0] exp;
    int n, busy_cnt;
    bit seen;
    exp      = model(x, y, s);
    n        = 0;
    busy_cnt = 0;
    seen     = 0;
    while (!seen && n < 20) begin
      step();
      n++;
      if (busy) busy_cnt++;
      if (done) seen = 1;
      if (junk && busy) begin
        start = 1'b1;
        a     = 16'($urandom);
        b     = 16'($urandom);
        sub   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(n), 32'd5);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd4);
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    check({tag, " result"}, 32'(result), 32'(exp[15:0]));
    check({tag, " cout"}, 32'(cout), 32'(exp[16]));
    check({tag, " ovf"}, 32'(ovf), 32'(exp[17]));
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s, input string tag);
    issue(x, y, s);
    wait_done(x, y, s, 1'b0, tag);
  endtask

  initial begin
    logic [15:0] rx, ry;
    logic        rs;
    logic [17:0] exp;

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    step();

    run_op(16'h1234, 16'h0FFF, 1'b0, "add_nocarry");
    check("add_nocarry value", 32'(result), 32'h2233);
    run_op(16'hFFFF, 16'h0001, 1'b0, "add_wrap");
    check("add_wrap value", 32'(result), 32'h0000);
    run_op(16'h7FFF, 16'h0001, 1'b0, "add_ovf");
    check("add_ovf flag", 32'(ovf), 32'd1);
    run_op(16'h0005, 16'h0007, 1'b1, "sub_borrow");
    check("sub_borrow value", 32'(result), 32'hFFFE);
    run_op(16'h8000, 16'h0001, 1'b1, "sub_ovf");
    check("sub_ovf value", 32'(result), 32'h7FFF);

    // Hold in IDLE: outputs must not move.
    step();
    step();
    check("idle hold result", 32'(result), 32'h7FFF);
    check("idle hold cout", 32'(cout), 32'd1);
    check("idle hold ovf", 32'(ovf), 32'd1);

    // start held during RUN with changing operands is ignored.
    issue(16'h0102, 16'h0304, 1'b0);
    wait_done(16'h0102, 16'h0304, 1'b0, 1'b1, "start_in_run");
    step();
    check("start_in_run no restart", 32'(busy), 32'd0);

    // Back-to-back: start in the DONE cycle; next done 5 cycles after this one.
    issue(16'hA5A5, 16'h5A5A, 1'b0);
    wait_done(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, "b2b_first");
    issue(16'h1000, 16'h2000, 1'b1);
    wait_done(16'h1000, 16'h2000, 1'b1, 1'b0, "b2b_second");

    // Reset during the 2nd RUN cycle discards everything.
    issue(16'h4321, 16'h1111, 1'b0);
    step();
    start = 1'b0;
    step();
    check("mid_reset pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_reset busy", 32'(busy), 32'd0);
    check("mid_reset done", 32'(done), 32'd0);
    check("mid_reset result", 32'(result), 32'd0);
    check("mid_reset cout", 32'(cout), 32'd0);
    check("mid_reset ovf", 32'(ovf), 32'd0);
    step();
    run_op(16'h0001, 16'h0001, 1'b0, "after_reset");
    check("after_reset value", 32'(result), 32'h0002);

    for (int i = 0; i < 24; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rs = 1'($urandom);
      if (i % 3 == 0) begin
        issue(rx, ry, rs);
        wait_done(rx, ry, rs, 1'b1, "rand_junk");
      end else begin
        run_op(rx, ry, rs, "rand");
      end
      exp = model(rx, ry, rs);
      if ($urandom_range(1, 0) == 1) begin
        step();
        check("rand idle hold", 32'(result), 32'(exp[15:0]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
